// File: rtl/shift_subtract_divider.sv
// Sequential restoring divider: 2n-bit dividend by n-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero reports all-ones quotient and the dividend's low half.
module shift_subtract_divider #(
  parameter int n = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*n-1:0] Z,
  input  logic [n-1:0]   B,
  output logic [2*n-1:0] Q,
  output logic [n-1:0]   R,
  output logic           busy,
  output logic           done,
  output logic           dbz
);

  localparam int CW = $clog2(2*n);
  localparam logic [CW-1:0] LAST = CW'(2*n-1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [2*n-1:0] dividend;
  logic [n-1:0]   divisor;
  logic [n:0]     p;
  logic [CW-1:0]  cnt;
  logic           zero_pend;

  logic [n:0]     p_shift;
  logic [n:0]     p_next;
  logic           ge;
  logic [2*n-1:0] div_next;

  always_comb begin
    p_shift  = {p[n-1:0], dividend[2*n-1]};
    ge       = (p_shift >= {1'b0, divisor});
    p_next   = ge ? (p_shift - {1'b0, divisor}) : p_shift;
    div_next = {dividend[2*n-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dividend  <= '0;
      divisor   <= '0;
      p         <= '0;
      cnt       <= '0;
      zero_pend <= 1'b0;
      Q         <= '0;
      R         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // A zero divisor parks in DONE for one cycle so the result lands on the following edge.
          if (zero_pend) begin
            Q         <= '1;
            R         <= dividend[n-1:0];
            dbz       <= 1'b1;
            done      <= 1'b1;
            zero_pend <= 1'b0;
          end else if (start) begin
            dividend <= Z;
            divisor  <= B;
            p        <= '0;
            cnt      <= '0;
            if (B != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state     <= DONE;
              zero_pend <= 1'b1;
            end
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
          p        <= p_next;
          dividend <= div_next;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) begin
            Q     <= div_next;
            R     <= p_next[n-1:0];
            dbz   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_subtract_divider.sv
// Self-checking bench for shift_subtract_divider: directed cases plus randomized operands
// compared against plain integer division.
module tb_shift_subtract_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] z;
  logic [15:0] b;
  logic [31:0] q;
  logic [15:0] r;
  logic        busy;
  logic        done;
  logic        dbz;

  int tests;
  int fails;

  shift_subtract_divider #(.n(16)) dut (
    .clk(clk), .rst(rst), .start(start), .Z(z), .B(b),
    .Q(q), .R(r), .busy(busy), .done(done), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [31:0] zi, input logic [15:0] bi,
                                output logic [31:0] qe, output logic [15:0] re,
                                output logic de);
    if (bi == 16'd0) begin
      qe = 32'hFFFF_FFFF;
      re = zi[15:0];
      de = 1'b1;
    end else begin
      qe = zi / {16'd0, bi};
      re = 16'(zi % {16'd0, bi});
      de = 1'b0;
    end
  endfunction

  // Launches one operation and waits (bounded) for done. lat counts the start edge as 1.
  // changed counts cycles before done where the visible result moved.
  task automatic run_op(input logic [31:0] zi, input logic [15:0] bi,
                        output int lat, output int busy_cycles, output int changed);
    logic [31:0] q0;
    logic [15:0] r0;
    @(negedge clk);
    z = zi; b = bi; start = 1'b1;
    q0 = q; r0 = r;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_cycles = busy ? 1 : 0;
    changed = 0;
    while (!done && lat < 100) begin
      if (q !== q0 || r !== r0) changed++;
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; z = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({q, r, busy, done, dbz} !== '0) begin
      fails++;
      $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0", q, r, busy, done, dbz);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc, ch;
    run_op(32'd6000, 16'd150, lat, bc, ch);
    tests++;
    if (lat !== 33) begin fails++; $display("FAIL basic_latency: got %0d want 33", lat); end
    tests++;
    if (q !== 32'd40 || r !== 16'd0 || dbz !== 1'b0) begin
      fails++; $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want q=40 r=0 dbz=0", q, r, dbz);
    end
    tests++;
    if (bc !== 32) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 32", bc); end
    tests++;
    if (ch !== 0) begin fails++; $display("FAIL basic_hold: result changed in %0d cycles, want 0", ch); end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || q !== 32'd40 || r !== 16'd0) begin
      fails++; $display("FAIL basic_pulse_hold: got done=%b q=%0d r=%0d want done=0 q=40 r=0", done, q, r);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, ch;
    run_op(32'd893, 16'd8, lat, bc, ch);
    tests++;
    if (lat !== 33 || q !== 32'd111 || r !== 16'd5) begin
      fails++; $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d want lat=33 q=111 r=5", lat, q, r);
    end
    z = 32'd960; b = 16'd32; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    lat = 1;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    tests++;
    if (lat !== 33 || q !== 32'd30 || r !== 16'd0) begin
      fails++; $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d want lat=33 q=30 r=0", lat, q, r);
    end
    @(posedge clk);
  endtask

  task automatic test_boundaries();
    logic [31:0] zs [4] = '{32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFF_FFFF, 32'd5};
    logic [15:0] bs [4] = '{16'd1, 16'hFFFF, 16'hFFFF, 16'd7};
    logic [31:0] qs [4] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0001_0001, 32'd0};
    logic [15:0] rs [4] = '{16'd0, 16'd0, 16'd0, 16'd5};
    int lat, bc, ch;
    for (int i = 0; i < 4; i++) begin
      run_op(zs[i], bs[i], lat, bc, ch);
      tests++;
      if (lat !== 33 || q !== qs[i] || r !== rs[i] || dbz !== 1'b0) begin
        fails++;
        $display("FAIL boundary_%0d: got lat=%0d q=%h r=%h dbz=%b want lat=33 q=%h r=%h dbz=0",
                 i, lat, q, r, dbz, qs[i], rs[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bc, ch;
    run_op(32'd12000, 16'd0, lat, bc, ch);
    tests++;
    if (lat !== 2 || q !== 32'hFFFF_FFFF || r !== 16'h2EE0 || dbz !== 1'b1) begin
      fails++; $display("FAIL dbz_result: got lat=%0d q=%h r=%h dbz=%b want lat=2 q=ffffffff r=2ee0 dbz=1",
                        lat, q, r, dbz);
    end
    tests++;
    if (bc !== 0) begin fails++; $display("FAIL dbz_busy: got %0d busy cycles want 0", bc); end
    run_op(32'd2048, 16'd4, lat, bc, ch);
    tests++;
    if (lat !== 33 || q !== 32'd512 || r !== 16'd0 || dbz !== 1'b0) begin
      fails++; $display("FAIL dbz_clear: got lat=%0d q=%0d r=%0d dbz=%b want lat=33 q=512 r=0 dbz=0",
                        lat, q, r, dbz);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    z = 32'd6000; b = 16'd150; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat >= 10 && lat < 20) begin
        start = 1'b1; z = $urandom; b = 16'($urandom_range(1, 65535));
        if (lat == 10) begin z = 32'd1; b = 16'd1; end
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    tests++;
    if (lat !== 33 || q !== 32'd40 || r !== 16'd0) begin
      fails++; $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d want lat=33 q=40 r=0", lat, q, r);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_abort();
    int lat, bc, ch, seen;
    @(negedge clk);
    z = 32'd6000; b = 16'd150; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({q, r, busy, done, dbz} !== '0) begin
      fails++; $display("FAIL abort_async: got q=%h r=%h busy=%b done=%b dbz=%b want all 0", q, r, busy, done, dbz);
    end
    #4 rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end
    run_op(32'd12000, 16'd100, lat, bc, ch);
    tests++;
    if (lat !== 33 || q !== 32'd120 || r !== 16'd0) begin
      fails++; $display("FAIL abort_recover: got lat=%0d q=%0d r=%0d want lat=33 q=120 r=0", lat, q, r);
    end
  endtask

  task automatic test_random();
    logic [31:0] zi, qe;
    logic [15:0] bi, re;
    logic de;
    int lat, bc, ch, want_lat;
    for (int i = 0; i < 24; i++) begin
      zi = $urandom;
      case ($urandom_range(0, 3))
        0: bi = 16'($urandom_range(0, 15));
        1: bi = 16'hFFFF - 16'($urandom_range(0, 3));
        default: bi = 16'($urandom);
      endcase
      if (i % 8 == 3) bi = 16'd0;
      model(zi, bi, qe, re, de);
      want_lat = de ? 2 : 33;
      run_op(zi, bi, lat, bc, ch);
      tests++;
      if (lat !== want_lat || q !== qe || r !== re || dbz !== de || ch !== 0) begin
        fails++;
        $display("FAIL random_%0d z=%h b=%h: got lat=%0d q=%h r=%h dbz=%b chg=%0d want lat=%0d q=%h r=%h dbz=%b chg=0",
                 i, zi, bi, lat, q, r, dbz, ch, want_lat, qe, re, de);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundaries();
    test_div_by_zero();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
